// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings and RX/TX FSM state enumerations.
package uart_pkg;

   localparam logic [1:0] ParNone = 2'b00;
   localparam logic [1:0] ParEven = 2'b01;
   localparam logic [1:0] ParOdd  = 2'b10;

   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

   // Mode 2'b11 is treated like ParNone.
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == ParEven) || (mode == ParOdd);
   endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with look-ahead read data; full blocks pushes, empty blocks pops.
module fifo #(
   parameter int unsigned DataW = 8,
   parameter int unsigned AddrW = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_i,
   input  logic             rd_i,
   input  logic [DataW-1:0] wdata_i,
   output logic [DataW-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned    Depth    = 1 << AddrW;
   localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

   logic [DataW-1:0] mem_q [Depth];
   logic [AddrW-1:0] wptr_q, rptr_q;
   logic [AddrW:0]   cnt_q;
   logic             wr_en, rd_en;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == DepthCnt);
   assign wr_en   = wr_i && !full_o;
   assign rd_en   = rd_i && !empty_o;
   // Empty reads as zero so the head output has a defined reset value.
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + AddrW'(1);
         if (rd_en) rptr_q <= rptr_q + AddrW'(1);
         case ({wr_en, rd_en})
            2'b10:   cnt_q <= cnt_q + (AddrW + 1)'(1);
            2'b01:   cnt_q <= cnt_q - (AddrW + 1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_ctrl_baud.sv
// Oversample tick generator: counts 0..dvsr and pulses tick on the wrap cycle.
module uart_ctrl_baud #(
   parameter int unsigned DvsrW = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [DvsrW-1:0] dvsr_i,
   output logic             tick_o
);

   logic [DvsrW-1:0] cnt_q, cnt_d, lim_q, lim_d, lim;
   logic             first_q, first_d;

   // The first period after reset follows the live divisor; later ones use the value
   // captured at the previous wrap.
   assign lim    = first_q ? dvsr_i : lim_q;
   assign tick_o = (cnt_q >= lim);

   always_comb begin
      cnt_d   = tick_o ? '0 : cnt_q + DvsrW'(1);
      lim_d   = tick_o ? dvsr_i : lim_q;
      first_d = first_q && !tick_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         lim_q   <= '0;
         first_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         lim_q   <= lim_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/uart_ctrl.sv
// UART with runtime divisor, optional parity, 1/2 stop bits, RX/TX FIFOs and sticky errors.
module uart_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DBIT   = 8,
   parameter int unsigned FIFO_W = 4,
   parameter int unsigned DVSR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic [1:0]        par_mode,
   input  logic              stop2,
   input  logic              rx,
   output logic              tx,
   input  logic              wr_uart,
   input  logic [7:0]        w_data,
   input  logic              rd_uart,
   output logic [7:0]        r_data,
   output logic              tx_full,
   output logic              tx_empty,
   output logic              rx_empty,
   output logic              rx_full,
   output logic              err_frame,
   output logic              err_par,
   output logic              err_ovr,
   input  logic              clr_err
);

   localparam logic [2:0] LastBit = 3'(DBIT - 1);

   logic tick;

   uart_ctrl_baud #(.DvsrW(DVSR_W)) u_baud (
      .clk_i (clk),
      .rst_ni(reset),
      .dvsr_i(dvsr),
      .tick_o(tick)
   );

   // ---------------- RX ----------------
   rx_state_e       rx_st_q, rx_st_d;
   logic [1:0]      rx_sync_q;
   logic            rx_in;
   logic [4:0]      rx_tk_q, rx_tk_d;
   logic [2:0]      rx_n_q, rx_n_d;
   logic [DBIT-1:0] rx_b_q, rx_b_d;
   logic [1:0]      rx_pm_q, rx_pm_d;
   logic            rx_st2_q, rx_st2_d;
   logic            rx_push;
   logic [2:0]      err_q, err_d, err_set;  // {frame, parity, overrun}

   assign rx_in = rx_sync_q[1];

   always_comb begin
      rx_st_d  = rx_st_q;
      rx_tk_d  = rx_tk_q;
      rx_n_d   = rx_n_q;
      rx_b_d   = rx_b_q;
      rx_pm_d  = rx_pm_q;
      rx_st2_d = rx_st2_q;
      rx_push  = 1'b0;
      err_set  = '0;
      unique case (rx_st_q)
         RxIdle: if (!rx_in) begin
            rx_st_d  = RxStart;
            rx_tk_d  = '0;
            rx_pm_d  = par_mode;
            rx_st2_d = stop2;
         end
         RxStart: if (tick) begin
            if (rx_tk_q == 5'd7) begin
               rx_tk_d = '0;
               rx_n_d  = '0;
               rx_st_d = rx_in ? RxIdle : RxData;
            end else rx_tk_d = rx_tk_q + 5'd1;
         end
         RxData: if (tick) begin
            if (rx_tk_q == 5'd15) begin
               rx_tk_d = '0;
               rx_b_d  = {rx_in, rx_b_q[DBIT-1:1]};
               if (rx_n_q == LastBit) rx_st_d = par_enabled(rx_pm_q) ? RxParity : RxStop;
               else rx_n_d = rx_n_q + 3'd1;
            end else rx_tk_d = rx_tk_q + 5'd1;
         end
         RxParity: if (tick) begin
            if (rx_tk_q == 5'd15) begin
               rx_tk_d    = '0;
               err_set[1] = ((^rx_b_q) ^ rx_in) != (rx_pm_q == ParOdd);
               rx_st_d    = RxStop;
            end else rx_tk_d = rx_tk_q + 5'd1;
         end
         RxStop: if (tick) begin
            if (rx_tk_q == 5'd15 && !rx_in) err_set[2] = 1'b1;
            if (rx_tk_q == (rx_st2_q ? 5'd31 : 5'd15)) begin
               rx_st_d = RxIdle;
               if (rx_full) err_set[0] = 1'b1;
               else rx_push = 1'b1;
            end else rx_tk_d = rx_tk_q + 5'd1;
         end
         default: rx_st_d = RxIdle;
      endcase
      // A new error event beats a simultaneous clear.
      err_d = err_set | (err_q & ~{3{clr_err}});
   end

   fifo #(.DataW(8), .AddrW(FIFO_W)) u_rx_fifo (
      .clk_i  (clk),
      .rst_ni (reset),
      .wr_i   (rx_push),
      .rd_i   (rd_uart),
      .wdata_i(8'(rx_b_q)),
      .rdata_o(r_data),
      .empty_o(rx_empty),
      .full_o (rx_full)
   );

   assign {err_frame, err_par, err_ovr} = err_q;

   // ---------------- TX ----------------
   tx_state_e       tx_st_q, tx_st_d;
   logic [4:0]      tx_tk_q, tx_tk_d;
   logic [2:0]      tx_n_q, tx_n_d;
   logic [DBIT-1:0] tx_b_q, tx_b_d;
   logic [1:0]      tx_pm_q, tx_pm_d;
   logic            tx_st2_q, tx_st2_d, tx_pb_q, tx_pb_d, tx_pop_q, tx_pop_d, tx_q, tx_d;
   logic [7:0]      tx_head;

   always_comb begin
      tx_st_d  = tx_st_q;
      tx_tk_d  = tx_tk_q;
      tx_n_d   = tx_n_q;
      tx_b_d   = tx_b_q;
      tx_pm_d  = tx_pm_q;
      tx_st2_d = tx_st2_q;
      tx_pb_d  = tx_pb_q;
      tx_pop_d = 1'b0;
      unique case (tx_st_q)
         // While the pop of the finished frame is in flight, empty is stale: wait one clk.
         TxIdle: if (!tx_pop_q && !tx_empty) begin
            tx_st_d  = TxStart;
            tx_tk_d  = '0;
            tx_b_d   = tx_head[DBIT-1:0];
            tx_pm_d  = par_mode;
            tx_st2_d = stop2;
            tx_pb_d  = (^tx_head[DBIT-1:0]) ^ (par_mode == ParOdd);
         end
         TxStart: if (tick) begin
            if (tx_tk_q == 5'd15) begin
               tx_tk_d = '0;
               tx_n_d  = '0;
               tx_st_d = TxData;
            end else tx_tk_d = tx_tk_q + 5'd1;
         end
         TxData: if (tick) begin
            if (tx_tk_q == 5'd15) begin
               tx_tk_d = '0;
               tx_b_d  = tx_b_q >> 1;
               if (tx_n_q == LastBit) tx_st_d = par_enabled(tx_pm_q) ? TxParity : TxStop;
               else tx_n_d = tx_n_q + 3'd1;
            end else tx_tk_d = tx_tk_q + 5'd1;
         end
         TxParity: if (tick) begin
            if (tx_tk_q == 5'd15) begin
               tx_tk_d = '0;
               tx_st_d = TxStop;
            end else tx_tk_d = tx_tk_q + 5'd1;
         end
         TxStop: if (tick) begin
            if (tx_tk_q == (tx_st2_q ? 5'd31 : 5'd15)) begin
               tx_st_d  = TxIdle;
               tx_pop_d = 1'b1;
            end else tx_tk_d = tx_tk_q + 5'd1;
         end
         default: tx_st_d = TxIdle;
      endcase
      case (tx_st_d)
         TxStart:  tx_d = 1'b0;
         TxData:   tx_d = tx_b_d[0];
         TxParity: tx_d = tx_pb_d;
         default:  tx_d = 1'b1;
      endcase
   end

   fifo #(.DataW(8), .AddrW(FIFO_W)) u_tx_fifo (
      .clk_i  (clk),
      .rst_ni (reset),
      .wr_i   (wr_uart),
      .rd_i   (tx_pop_q),
      .wdata_i(w_data),
      .rdata_o(tx_head),
      .empty_o(tx_empty),
      .full_o (tx_full)
   );

   assign tx = tx_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_sync_q <= 2'b11;
         rx_st_q   <= RxIdle;
         rx_tk_q   <= '0;
         rx_n_q    <= '0;
         rx_b_q    <= '0;
         rx_pm_q   <= ParNone;
         rx_st2_q  <= 1'b0;
         err_q     <= '0;
         tx_st_q   <= TxIdle;
         tx_tk_q   <= '0;
         tx_n_q    <= '0;
         tx_b_q    <= '0;
         tx_pm_q   <= ParNone;
         tx_st2_q  <= 1'b0;
         tx_pb_q   <= 1'b0;
         tx_pop_q  <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         rx_sync_q <= {rx_sync_q[0], rx};
         rx_st_q   <= rx_st_d;
         rx_tk_q   <= rx_tk_d;
         rx_n_q    <= rx_n_d;
         rx_b_q    <= rx_b_d;
         rx_pm_q   <= rx_pm_d;
         rx_st2_q  <= rx_st2_d;
         err_q     <= err_d;
         tx_st_q   <= tx_st_d;
         tx_tk_q   <= tx_tk_d;
         tx_n_q    <= tx_n_d;
         tx_b_q    <= tx_b_d;
         tx_pm_q   <= tx_pm_d;
         tx_st2_q  <= tx_st2_d;
         tx_pb_q   <= tx_pb_d;
         tx_pop_q  <= tx_pop_d;
         tx_q      <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: loopback vector table plus hand-written RX/TX corner sequences.
module tb_uart_ctrl;

   localparam int Dvsr = 3;
   localparam int Bit  = 16 * (Dvsr + 1);
   localparam int Half = Bit / 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] dvsr;
   logic [1:0]  par_mode;
   logic        stop2, rx, tx, wr_uart, rd_uart, clr_err;
   logic [7:0]  w_data, r_data;
   logic        tx_full, tx_empty, rx_empty, rx_full, err_frame, err_par, err_ovr;
   logic        rx_drv, loop_en;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] data;
      logic [1:0] pm;
      logic       st2;
      logic       has_par;
      logic       exp_par;
   } vec_t;

   vec_t vecs[8];

   assign rx = loop_en ? tx : rx_drv;

   uart_ctrl #(.DBIT(8), .FIFO_W(2), .DVSR_W(16)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .dvsr     (dvsr),
      .par_mode (par_mode),
      .stop2    (stop2),
      .rx       (rx),
      .tx       (tx),
      .wr_uart  (wr_uart),
      .w_data   (w_data),
      .rd_uart  (rd_uart),
      .r_data   (r_data),
      .tx_full  (tx_full),
      .tx_empty (tx_empty),
      .rx_empty (rx_empty),
      .rx_full  (rx_full),
      .err_frame(err_frame),
      .err_par  (err_par),
      .err_ovr  (err_ovr),
      .clr_err  (clr_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #700000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_tx(input logic [7:0] d);
      wr_uart = 1'b1;
      w_data  = d;
      @(negedge clk);
      wr_uart = 1'b0;
   endtask

   task automatic pop_rx();
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
   endtask

   task automatic wait_rx(input int limit, output bit ok);
      int n = 0;
      ok = (rx_empty === 1'b0);
      while (!ok && n < limit) begin
         @(negedge clk);
         n++;
         if (rx_empty === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic wait_tx_low(input int limit, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!ok && n < limit) begin
         @(negedge clk);
         n++;
         if (tx === 1'b0) ok = 1'b1;
      end
   endtask

   // Samples a TX frame at bit centres, starting from the falling edge of the start bit.
   task automatic capture_tx(input bit has_par, input bit two_stop, output logic [7:0] d,
                             output logic p, output logic s1, output logic s2, output bit ok);
      d = '0; p = 1'b0; s1 = 1'b0; s2 = 1'b0;
      wait_tx_low(400, ok);
      if (ok) begin
         wait_clk(Half);
         for (int i = 0; i < 8; i++) begin
            wait_clk(Bit);
            d[i] = tx;
         end
         if (has_par) begin
            wait_clk(Bit);
            p = tx;
         end
         wait_clk(Bit);
         s1 = tx;
         s2 = 1'b1;
         if (two_stop) begin
            wait_clk(Bit);
            s2 = tx;
         end
      end
   endtask

   // A bad stop bit is held low only briefly past its centre so the receiver sees a glitch,
   // not a new start bit, when it returns to idle.
   task automatic send_frame(input logic [7:0] d, input bit has_par, input bit pbit,
                             input bit stop_ok);
      rx_drv = 1'b0;
      wait_clk(Bit);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         wait_clk(Bit);
      end
      if (has_par) begin
         rx_drv = pbit;
         wait_clk(Bit);
      end
      rx_drv = stop_ok;
      if (stop_ok) wait_clk(Bit);
      else begin
         wait_clk(48);
         rx_drv = 1'b1;
         wait_clk(16);
      end
      rx_drv = 1'b1;
      wait_clk(Bit);
   endtask

   logic [7:0] cd;
   logic       cp, cs1, cs2;
   bit         ok;
   int         t1, t2, k, nz;

   initial begin
      vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h07, 2'b01, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{8'h07, 2'b10, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'h81, 2'b01, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'h03, 2'b10, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{8'h5A, 2'b11, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{8'hE0, 2'b01, 1'b0, 1'b1, 1'b1};
      vecs[7] = '{8'h3C, 2'b00, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0; dvsr = 16'(Dvsr); par_mode = 2'b00; stop2 = 1'b0;
      wr_uart = 1'b0; w_data = '0; rd_uart = 1'b0; clr_err = 1'b0;
      rx_drv = 1'b1; loop_en = 1'b0;
      wait_clk(3);
      check("rst_tx", tx, 1);
      check("rst_tx_empty", tx_empty, 1);
      check("rst_rx_empty", rx_empty, 1);
      check("rst_tx_full", tx_full, 0);
      check("rst_rx_full", rx_full, 0);
      check("rst_r_data", r_data, 0);
      check("rst_errs", {err_frame, err_par, err_ovr}, 0);
      rst_n = 1'b1;
      wait_clk(5);

      // Loopback of two back-to-back frames.
      loop_en = 1'b1;
      push_tx(8'hA5);
      push_tx(8'h3C);
      wait_tx_low(200, ok);
      check("lb_first_start", ok, 1);
      t1 = cyc;
      wait_clk(600);
      wait_tx_low(200, ok);
      check("lb_second_start", ok, 1);
      t2 = cyc;
      // Start-bit tick phase plus the one-clk pop leave a few clk of slack around 640.
      check("lb_frame_len", (t2 - t1 >= 638) && (t2 - t1 <= 644), 1);
      wait_rx(200, ok);
      check("lb_rx1_avail", ok, 1);
      check("lb_rx1", r_data, 8'hA5);
      pop_rx();
      wait_rx(800, ok);
      check("lb_rx2_avail", ok, 1);
      check("lb_rx2", r_data, 8'h3C);
      pop_rx();
      check("lb_rx_empty", rx_empty, 1);
      check("lb_errs", {err_frame, err_par, err_ovr}, 0);
      wait_clk(Bit);
      check("lb_tx_empty", tx_empty, 1);

      // Table-driven loopback over parity and stop-bit modes.
      foreach (vecs[i]) begin
         par_mode = vecs[i].pm;
         stop2    = vecs[i].st2;
         push_tx(vecs[i].data);
         capture_tx(vecs[i].has_par, vecs[i].st2, cd, cp, cs1, cs2, ok);
         check($sformatf("v%0d_start", i), ok, 1);
         check($sformatf("v%0d_txdata", i), cd, vecs[i].data);
         if (vecs[i].has_par) check($sformatf("v%0d_parbit", i), cp, vecs[i].exp_par);
         check($sformatf("v%0d_stop", i), {cs1, cs2}, 2'b11);
         wait_rx(200, ok);
         check($sformatf("v%0d_rx_avail", i), ok, 1);
         check($sformatf("v%0d_rxdata", i), r_data, vecs[i].data);
         check($sformatf("v%0d_errs", i), {err_frame, err_par, err_ovr}, 0);
         pop_rx();
         check($sformatf("v%0d_rx_empty", i), rx_empty, 1);
      end
      wait_clk(2 * Bit);

      // TX FIFO full: the fifth write is dropped.
      par_mode = 2'b00;
      stop2    = 1'b0;
      for (int i = 0; i < 5; i++) push_tx(8'h61 + 8'(i));
      check("txf_full", tx_full, 1);
      for (int i = 0; i < 4; i++) begin
         wait_rx(800, ok);
         check($sformatf("txf_rx%0d_avail", i), ok, 1);
         check($sformatf("txf_rx%0d", i), r_data, 8'h61 + 8'(i));
         pop_rx();
      end
      wait_clk(1000);
      check("txf_no_fifth", rx_empty, 1);
      check("txf_tx_empty", tx_empty, 1);

      // Parity error on an injected frame; byte is still stored.
      loop_en  = 1'b0;
      par_mode = 2'b01;
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      wait_rx(50, ok);
      check("par_rx_avail", ok, 1);
      check("par_err_par", err_par, 1);
      check("par_rdata", r_data, 8'h07);
      check("par_other_errs", {err_frame, err_ovr}, 0);
      pop_rx();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("par_cleared", err_par, 0);

      // Overrun with a 4-deep RX FIFO.
      par_mode = 2'b00;
      for (int i = 0; i < 4; i++) send_frame(8'h11 * 8'(i + 1), 1'b0, 1'b0, 1'b1);
      check("ovr_full4", rx_full, 1);
      check("ovr_not_yet", err_ovr, 0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      check("ovr_set", err_ovr, 1);
      check("ovr_still_full", rx_full, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovr_rd%0d", i), r_data, 8'h11 * 8'(i + 1));
         pop_rx();
      end
      check("ovr_drained", rx_empty, 1);
      pop_rx();
      check("ovr_pop_empty", {rx_empty, rx_full}, 2'b10);

      // Framing error, then one clear drops every flag.
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      wait_rx(50, ok);
      check("frm_rx_avail", ok, 1);
      check("frm_err_frame", err_frame, 1);
      check("frm_rdata", r_data, 8'h5A);
      check("frm_ovr_sticky", err_ovr, 1);
      pop_rx();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("frm_cleared", {err_frame, err_par, err_ovr}, 0);

      // Short low glitch on rx: no byte, no error, receiver still usable.
      rx_drv = 1'b0;
      wait_clk(4 * (Dvsr + 1));
      rx_drv = 1'b1;
      wait_clk(3 * Bit);
      check("gl_no_byte", rx_empty, 1);
      check("gl_no_err", {err_frame, err_par, err_ovr}, 0);
      send_frame(8'hC6, 1'b0, 1'b0, 1'b1);
      wait_rx(50, ok);
      check("gl_rx_after", r_data, 8'hC6);
      pop_rx();

      // Reset during TX data bit 3.
      push_tx(8'h96);
      wait_tx_low(200, ok);
      check("rst_tx_started", ok, 1);
      wait_clk(Bit + 3 * Bit + Half);
      rst_n = 1'b0;
      #1;
      check("rstmid_tx", tx, 1);
      check("rstmid_tx_empty", tx_empty, 1);
      wait_clk(3);
      rst_n = 1'b1;
      k = 0;
      while (dut.u_baud.tick_o !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      // Tick is high during the (dvsr+1)-th clk after release, i.e. dvsr negedges later.
      check("rstmid_first_tick", k, Dvsr);
      nz = 0;
      repeat (1500) begin
         @(negedge clk);
         if (tx !== 1'b1) nz++;
      end
      check("rstmid_tx_quiet", nz, 0);
      push_tx(8'h69);
      capture_tx(1'b0, 1'b0, cd, cp, cs1, cs2, ok);
      check("rstmid_new_start", ok, 1);
      check("rstmid_new_data", cd, 8'h69);
      check("rstmid_new_stop", cs1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
